// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus between the UART receiver/register block (master) and the FIFO (slave).
// Carries write, pop, control and status signals; clock and reset stay outside.
interface uart_rx_fifo_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  wr_perr;
  logic                  wr_ferr;
  logic                  rd_en;
  logic                  flush;
  logic                  clr_ovf;
  logic [7:0]            rd_data;
  logic                  rd_perr;
  logic                  rd_ferr;
  logic                  empty;
  logic                  full;
  logic                  afull;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;

  modport master (
    output wr_en, wr_data, wr_perr, wr_ferr, rd_en, flush, clr_ovf,
    input  rd_data, rd_perr, rd_ferr, empty, full, afull, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, wr_perr, wr_ferr, rd_en, flush, clr_ovf,
    output rd_data, rd_perr, rd_ferr, empty, full, afull, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with sticky overflow. Define RX_FIFO_ERR_TAG_EN to store the
// parity/framing error tags alongside each byte; otherwise rd_perr/rd_ferr read 0.
module uart_rx_fifo #(
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  uart_rx_fifo_if.slave     bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
`ifdef RX_FIFO_ERR_TAG_EN
  localparam int WORD_W = 10;
`else
  localparam int WORD_W = 8;
`endif

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 8) begin : g_bad_aw
    $error("uart_rx_fifo: ADDR_WIDTH out of range 1..8");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_af
    $error("uart_rx_fifo: AFULL_LEVEL out of range 1..DEPTH");
  end

  logic [WORD_W-1:0]     mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [WORD_W-1:0]     head_q, head_d;
  logic [WORD_W-1:0]     wr_word;
  logic                  empty, full;
  logic                  wr_ok, rd_ok, ovf_evt, mem_we;

`ifdef RX_FIFO_ERR_TAG_EN
  assign wr_word = {bus.wr_ferr, bus.wr_perr, bus.wr_data};
`else
  logic unused_tags;
  assign wr_word     = bus.wr_data;
  assign unused_tags = bus.wr_perr ^ bus.wr_ferr;
`endif

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside rd_en.
  assign wr_ok   = bus.wr_en & (~full | bus.rd_en);
  assign rd_ok   = bus.rd_en & ~empty;
  assign ovf_evt = bus.wr_en & full & ~bus.rd_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    head_d   = head_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      mem_we = wr_ok & ~RESET;
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (bus.clr_ovf) ovf_d = 1'b0;
    if (ovf_evt && !bus.flush) ovf_d = 1'b1;

    // Head register tracks mem[rd_ptr]; a write landing on the next head slot is forwarded
    // directly since the array only updates at the same edge. Holds its value while empty.
    if (count_d != '0) begin
      if (mem_we && (wr_ptr_q == rd_ptr_d)) head_d = wr_word;
      else                                  head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_word;
  end

  assign bus.rd_data  = head_q[7:0];
`ifdef RX_FIFO_ERR_TAG_EN
  assign bus.rd_perr  = head_q[8];
  assign bus.rd_ferr  = head_q[9];
`else
  assign bus.rd_perr  = 1'b0;
  assign bus.rd_ferr  = 1'b0;
`endif
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.afull    = (count_q >= CNT_W'(AFULL_LEVEL));
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed table-driven bench for uart_rx_fifo (DEPTH 16, AFULL_LEVEL 12), plus a
// hand-written bypass/wrap sequence holding a single entry through many simultaneous rd/wr.
module tb_uart_rx_fifo;

`ifdef RX_FIFO_ERR_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;

  uart_rx_fifo_if #(.ADDR_WIDTH(4)) bus ();

  uart_rx_fifo #(.ADDR_WIDTH(4), .AFULL_LEVEL(12)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, wr, rd, fl, clr, perr, ferr;
    logic [7:0] wd;
    int         e_count;
    logic       e_ovf;
    logic       chk;
    logic [7:0] e_data;
    logic       e_perr, e_ferr;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic rst, wr, input logic [7:0] wd, input logic perr, ferr,
                              input logic rd, fl, clr, input int cnt, input logic ovf,
                              input logic chk, input logic [7:0] d, input logic ep, ef);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wd = wd; v.perr = perr; v.ferr = ferr;
    v.rd = rd; v.fl = fl; v.clr = clr; v.e_count = cnt; v.e_ovf = ovf;
    v.chk = chk; v.e_data = d; v.e_perr = ep; v.e_ferr = ef;
    vq.push_back(v);
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, wr, input logic [7:0] wd, input logic perr, ferr,
                       input logic rd, fl, clr);
    RESET = rst; bus.wr_en = wr; bus.wr_data = wd; bus.wr_perr = perr; bus.wr_ferr = ferr;
    bus.rd_en = rd; bus.flush = fl; bus.clr_ovf = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_status(input int idx, input int cnt, input logic ovf);
    check("count",    idx, 32'(bus.count),    32'(cnt));
    check("empty",    idx, 32'(bus.empty),    32'(cnt == 0));
    check("full",     idx, 32'(bus.full),     32'(cnt == 16));
    check("afull",    idx, 32'(bus.afull),    32'(cnt >= 12));
    check("overflow", idx, 32'(bus.overflow), 32'(ovf));
  endtask

  initial begin
    RESET = 1'b1; bus.wr_en = 0; bus.wr_data = '0; bus.wr_perr = 0; bus.wr_ferr = 0;
    bus.rd_en = 0; bus.flush = 0; bus.clr_ovf = 0;

    //  rst wr wd     pe fe rd fl cl  cnt ovf chk data   ep   ef
    add(1, 0, 8'h00, 0, 0, 0, 0, 0,  0,  0,  1, 8'h00, 0,   0);
    add(0, 1, 8'hA5, 0, 0, 0, 0, 0,  1,  0,  1, 8'hA5, 0,   0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0,  0,  0,  0, 8'h00, 0,   0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0,  0,  0,  0, 8'h00, 0,   0);
    add(0, 1, 8'h33, 0, 0, 1, 0, 0,  1,  0,  1, 8'h33, 0,   0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0,  0,  0,  0, 8'h00, 0,   0);
    for (int i = 0; i < 16; i++)
      add(0, 1, 8'(i), 0, 0, 0, 0, 0, i + 1, 0, 1, 8'h00, 0, 0);
    add(0, 1, 8'h77, 0, 0, 1, 0, 0, 16,  0,  1, 8'h01, 0,   0);
    add(0, 1, 8'h55, 0, 0, 0, 0, 0, 16,  1,  1, 8'h01, 0,   0);
    add(0, 1, 8'h56, 0, 0, 0, 0, 1, 16,  1,  1, 8'h01, 0,   0);
    add(0, 0, 8'h00, 0, 0, 0, 0, 1, 16,  0,  1, 8'h01, 0,   0);
    add(0, 1, 8'h57, 0, 0, 0, 0, 0, 16,  1,  1, 8'h01, 0,   0);
    for (int j = 1; j <= 15; j++)
      add(0, 0, 8'h00, 0, 0, 1, 0, 0, 16 - j, 1, 1, (j < 15) ? 8'(1 + j) : 8'h77, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0,  0,  1,  0, 8'h00, 0,   0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 8'(8'h80 + i), 0, 0, 0, 0, 0, i + 1, 1, 1, 8'h80, 0, 0);
    add(0, 1, 8'h99, 0, 0, 1, 1, 0,  0,  1,  0, 8'h00, 0,   0);
    add(0, 1, 8'hAA, 0, 0, 0, 0, 0,  1,  1,  1, 8'hAA, 0,   0);
    add(0, 1, 8'hAB, 0, 0, 0, 0, 0,  2,  1,  1, 8'hAA, 0,   0);
    add(1, 1, 8'hCC, 0, 0, 0, 0, 0,  0,  0,  1, 8'h00, 0,   0);
    add(0, 1, 8'h12, 1, 0, 0, 0, 0,  1,  0,  1, 8'h12, TAG, 0);
    add(0, 1, 8'h34, 0, 1, 0, 0, 0,  2,  0,  1, 8'h12, TAG, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0,  1,  0,  1, 8'h34, 0,   TAG);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0,  0,  0,  0, 8'h00, 0,   0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].wr, vq[i].wd, vq[i].perr, vq[i].ferr, vq[i].rd, vq[i].fl, vq[i].clr);
      check_status(i, vq[i].e_count, vq[i].e_ovf);
      if (vq[i].chk) begin
        check("rd_data", i, 32'(bus.rd_data), 32'(vq[i].e_data));
        check("rd_perr", i, 32'(bus.rd_perr), 32'(vq[i].e_perr));
        check("rd_ferr", i, 32'(bus.rd_ferr), 32'(vq[i].e_ferr));
      end
    end

    // One entry held while rd/wr pulse together: every new byte must appear next cycle.
    drive(0, 1, 8'h40, 0, 0, 0, 0, 0);
    check_status(1000, 1, 0);
    check("byp_data", 1000, 32'(bus.rd_data), 32'h40);
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 8'(8'h41 + k), 0, 0, 1, 0, 0);
      check("byp_count", 1001 + k, 32'(bus.count), 32'd1);
      check("byp_data",  1001 + k, 32'(bus.rd_data), 32'(8'h41 + k));
    end
    drive(0, 0, 8'h00, 0, 0, 1, 0, 0);
    check_status(1100, 0, 0);

    drive(0, 0, 8'h00, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
